backend_cmd_arbiter: RTL

// Shares one Backend_Controller command/data port among NUM_REQ frontend requesters.
// - Arbitration: round-robin over the requesters.
// - Read ordering: a tag FIFO records which requester issued each read, in issue order.
// - Read return: backend read data is sent back to the owning requester through one response register.
// - Backpressure: the backend is stalled while that response register is unconsumed.

---
 rtl/backend_cmd_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/backend_cmd_arbiter.sv
// backend_cmd_arbiter
// Shares a single Backend_Controller command/data port among NUM_REQ
// frontend requesters. Requests are granted round-robin. Every issued read
// pushes its requester index into a tag FIFO, so returning read data can be
// routed back to the requester that asked for it. Returned data is held in
// one response register, and the backend is stalled until that register is
// consumed.
//
// Ports
//   clk, power_on_rst             clock, async active-high reset
//   req_valid/ready/is_read       per-requester command handshake
//   req_cmd, req_wdata            packed per-requester command / write data
//   rsp_valid/ready, rsp_data     per-requester read response, shared data bus
//   o_frontend_command_valid/
//   o_frontend_command/
//   o_frontend_write_data         command port toward the backend
//   i_backend_controller_ready    backend accepts the presented command
//   i_backend_read_data(_valid)   read data returning from the backend
//   o_backend_controller_stall    response register is full and unconsumed
//   o_frontend_controller_ready   inverse of stall
//   o_err                         sticky: [0] data with no tag, [1] data while stalled
module backend_cmd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CMD_BITS  = 32,
    parameter int DATA_BITS = 64,
    parameter int RDQ_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         power_on_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_is_read,
    input  logic [NUM_REQ*CMD_BITS-1:0]  req_cmd,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [DATA_BITS-1:0]         rsp_data,
    output logic                         o_frontend_command_valid,
    output logic [CMD_BITS-1:0]          o_frontend_command,
    output logic [DATA_BITS-1:0]         o_frontend_write_data,
    input  logic                         i_backend_controller_ready,
    input  logic [DATA_BITS-1:0]         i_backend_read_data,
    input  logic                         i_backend_read_data_valid,
    output logic                         o_backend_controller_stall,
    output logic                         o_frontend_controller_ready,
    output logic [1:0]                   o_err
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int AW    = $clog2(RDQ_DEPTH);

    logic [TAG_W-1:0]     ptr_q, ptr_d;

    logic [TAG_W-1:0]     tag_mem_q [RDQ_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;

    logic                 rsp_full_q, rsp_full_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
    logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;

    logic [1:0]           err_q, err_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 rdq_full, rdq_empty;
    logic [TAG_W-1:0]     gnt_idx;
    logic                 issue, push, pop, stall;

    // A pop in the same cycle does not unmask reads: full is the registered count.
    assign rdq_full  = (count_q == (AW+1)'(RDQ_DEPTH));
    assign rdq_empty = (count_q == '0);
    assign eligible  = req_valid & ~(req_is_read & {NUM_REQ{rdq_full}});

    // First eligible index at or after ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int  idx;
        logic found;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                gnt_idx = idx[TAG_W-1:0];
            end
        end
    end

    assign o_frontend_command_valid = |eligible;
    assign o_frontend_command       = req_cmd[gnt_idx*CMD_BITS +: CMD_BITS];
    assign o_frontend_write_data    = req_wdata[gnt_idx*DATA_BITS +: DATA_BITS];

    assign issue     = o_frontend_command_valid & i_backend_controller_ready;
    assign req_ready = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign push      = issue & req_is_read[gnt_idx];

    assign stall                       = rsp_full_q & ~rsp_ready[rsp_tag_q];
    assign o_backend_controller_stall  = stall;
    assign o_frontend_controller_ready = ~stall;

    // Returned data is only accepted when it has somewhere to go and a tag
    // to route it by; otherwise it is dropped and the tag stays queued.
    assign pop = i_backend_read_data_valid & ~stall & ~rdq_empty;

    always_comb begin
        if (!issue)
            ptr_d = ptr_q;
        else if (gnt_idx == TAG_W'(NUM_REQ-1))
            ptr_d = '0;
        else
            ptr_d = gnt_idx + 1'b1;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // Load wins over release, which gives back-to-back responses with no bubble.
    always_comb begin
        rsp_full_d = rsp_full_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_data_d = rsp_data_q;
        if (pop) begin
            rsp_full_d = 1'b1;
            rsp_tag_d  = tag_mem_q[rd_ptr_q];
            rsp_data_d = i_backend_read_data;
        end else if (rsp_full_q && rsp_ready[rsp_tag_q]) begin
            rsp_full_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (i_backend_read_data_valid && rdq_empty) err_d[0] = 1'b1;
        if (i_backend_read_data_valid && stall)     err_d[1] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_full_q) rsp_valid[rsp_tag_q] = 1'b1;
    end

    assign rsp_data = rsp_data_q;
    assign o_err    = err_q;

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            ptr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rsp_full_q <= 1'b0;
            rsp_tag_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            rsp_full_q <= rsp_full_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Tag storage needs no reset; entries are only read below count_q.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
    end

endmodule
